dm_abstract_cmd_engine: RTL and testbench

// Debug Module side of the debug register access bus. Accepts RISC-V

---
 rtl/dm_abstract_cmd_engine.sv | 176 +++++++++++++++++
 tb/tb_dm_abstract_cmd_engine.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_abstract_cmd_engine.sv
// Debug Module abstract-command engine: runs Access Register commands over the dm_reg_rd_wr bus.
// Latency: busy for ACCESS_CYCLES+2 cycles on a transfer, 2 cycles on error or transfer=0.
// Backpressure: none; writes that arrive while busy are dropped and flagged as cmderr=1.
//
// Ports:
//   clk_i, reset_i                 clock, synchronous active-low reset
//   cmd_wr_en_i/cmd_wr_data_i      DMI write to the command register
//   data0_wr_en_i/data0_wr_data_i  DMI write to data0; data0_o is the current value
//   cmderr_clr_i                   write-1-to-clear mask for cmderr
//   busy_o, cmderr_o               abstractcs.busy and sticky abstractcs.cmderr
//   hart_halted_i                  hart is in debug mode
//   dm_reg_rd_wr_*                 register access bus to the hart; data is tri-stated unless writing
module dm_abstract_cmd_engine #(
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_wr_en_i,
  input  logic [31:0] cmd_wr_data_i,
  input  logic        data0_wr_en_i,
  input  logic [31:0] data0_wr_data_i,
  output logic [31:0] data0_o,
  input  logic [2:0]  cmderr_clr_i,
  output logic        busy_o,
  output logic [2:0]  cmderr_o,
  input  logic        hart_halted_i,
  output logic        dm_reg_rd_wr_en_o,
  output logic        dm_reg_rd_wr_o,
  output logic [15:0] dm_reg_rd_wr_address_o,
  inout  wire  [31:0] dm_reg_rd_wr_data_io
);

  localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_nxt;
  logic [7:0]         cmdtype_q;
  logic [2:0]         aarsize_q;
  logic               postexec_q;
  logic               transfer_q;
  logic               write_q;
  logic [15:0]        regno_q;
  logic [31:0]        data0_q;
  logic [2:0]         cmderr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               cmd_accept;
  logic               cnt_load;
  logic [2:0]         chk_err;
  logic [2:0]         err_set_val;
  logic               busy_wr_err;
  logic               regno_ok;
  logic               read_capture;

  // Bits 23 (reserved) and 19 (aarpostincrement) carry no behaviour here.
  logic unused_cmd_bits;
  assign unused_cmd_bits = cmd_wr_data_i[23] ^ cmd_wr_data_i[19];

  assign regno_ok = ((regno_q >= 16'h07B0) && (regno_q <= 16'h07B2)) ||
                    ((regno_q >= 16'h1000) && (regno_q <= 16'h101F));

  assign busy_o                 = (state_q != IDLE);
  assign data0_o                = data0_q;
  assign cmderr_o               = cmderr_q;
  assign dm_reg_rd_wr_en_o      = (state_q == ACCESS);
  assign dm_reg_rd_wr_o         = (state_q == ACCESS) ? write_q : 1'b0;
  assign dm_reg_rd_wr_address_o = (state_q == ACCESS) ? regno_q : 16'h0000;
  assign dm_reg_rd_wr_data_io   = ((state_q == ACCESS) && write_q) ? data0_q : 32'bz;

  assign busy_wr_err  = busy_o && (cmd_wr_en_i || data0_wr_en_i);
  assign read_capture = (state_q == ACCESS) && (cnt_q == '0) && !write_q;
  // A command's own check result takes precedence over a concurrent busy-write error.
  assign err_set_val  = (chk_err != 3'd0) ? chk_err : (busy_wr_err ? 3'd1 : 3'd0);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    cmd_accept = 1'b0;
    cnt_load   = 1'b0;
    chk_err    = 3'd0;
    case (state_q)
      IDLE: begin
        if (cmd_wr_en_i && (cmderr_q == 3'd0)) begin
          cmd_accept = 1'b1;
          state_nxt  = CHECK;
        end
      end
      CHECK: begin
        if ((cmdtype_q != 8'd0) || (aarsize_q != 3'd2) || postexec_q) begin
          chk_err   = 3'd2;
          state_nxt = DONE;
        end else if (transfer_q && !regno_ok) begin
          chk_err   = 3'd2;
          state_nxt = DONE;
        end else if (!hart_halted_i) begin
          chk_err   = 3'd4;
          state_nxt = DONE;
        end else if (!transfer_q) begin
          state_nxt = DONE;
        end else begin
          cnt_load  = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        // Halt status is not re-checked here: a started access always runs to completion.
        if (cnt_q == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cmdtype_q  <= 8'd0;
      aarsize_q  <= 3'd0;
      postexec_q <= 1'b0;
      transfer_q <= 1'b0;
      write_q    <= 1'b0;
      regno_q    <= 16'h0000;
      data0_q    <= 32'h0000_0000;
      cmderr_q   <= 3'd0;
      cnt_q      <= '0;
    end else begin
      if (cmd_accept) begin
        cmdtype_q  <= cmd_wr_data_i[31:24];
        aarsize_q  <= cmd_wr_data_i[22:20];
        postexec_q <= cmd_wr_data_i[18];
        transfer_q <= cmd_wr_data_i[17];
        write_q    <= cmd_wr_data_i[16];
        regno_q    <= cmd_wr_data_i[15:0];
      end

      // Idle data0 writes land on the same edge as a command write, so the command sees them.
      if (!busy_o && data0_wr_en_i) begin
        data0_q <= data0_wr_data_i;
      end else if (read_capture) begin
        data0_q <= dm_reg_rd_wr_data_io;
      end

      // First error sticks; a set beats a same-cycle clear.
      if ((err_set_val != 3'd0) && (cmderr_q == 3'd0)) begin
        cmderr_q <= err_set_val;
      end else begin
        cmderr_q <= cmderr_q & ~cmderr_clr_i;
      end

      if (cnt_load) begin
        cnt_q <= CNT_W'(ACCESS_CYCLES - 1);
      end else if ((state_q == ACCESS) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dm_abstract_cmd_engine.sv
module tb_dm_abstract_cmd_engine;

  localparam int N = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cmd_wr_en_i;
  logic [31:0] cmd_wr_data_i;
  logic        data0_wr_en_i;
  logic [31:0] data0_wr_data_i;
  logic [31:0] data0_o;
  logic [2:0]  cmderr_clr_i;
  logic        busy_o;
  logic [2:0]  cmderr_o;
  logic        hart_halted_i;
  logic        dm_reg_rd_wr_en_o;
  logic        dm_reg_rd_wr_o;
  logic [15:0] dm_reg_rd_wr_address_o;
  wire  [31:0] reg_bus;

  logic        resp_drive;
  logic [31:0] resp_dat;
  assign reg_bus = resp_drive ? resp_dat : 32'bz;

  int total = 0;
  int bad   = 0;

  // Reference state of the DM as seen by the debugger.
  logic [31:0] m_data0;
  logic [2:0]  m_cmderr;

  dm_abstract_cmd_engine #(.ACCESS_CYCLES(N)) dut (
    .clk_i                  (clk_i),
    .reset_i                (reset_i),
    .cmd_wr_en_i            (cmd_wr_en_i),
    .cmd_wr_data_i          (cmd_wr_data_i),
    .data0_wr_en_i          (data0_wr_en_i),
    .data0_wr_data_i        (data0_wr_data_i),
    .data0_o                (data0_o),
    .cmderr_clr_i           (cmderr_clr_i),
    .busy_o                 (busy_o),
    .cmderr_o               (cmderr_o),
    .hart_halted_i          (hart_halted_i),
    .dm_reg_rd_wr_en_o      (dm_reg_rd_wr_en_o),
    .dm_reg_rd_wr_o         (dm_reg_rd_wr_o),
    .dm_reg_rd_wr_address_o (dm_reg_rd_wr_address_o),
    .dm_reg_rd_wr_data_io   (reg_bus)
  );

  always #5 clk_i = ~clk_i;

  // Error code an Access Register command earns, straight from the command-field rules.
  function automatic logic [2:0] predict_err(input logic [31:0] c, input logic h);
    int r;
    r = int'(c[15:0]);
    if (c[31:24] != 8'd0 || c[22:20] != 3'd2 || c[18]) return 3'd2;
    if (c[17] && !((r >= 'h07B0 && r <= 'h07B2) || (r >= 'h1000 && r <= 'h101F))) return 3'd2;
    if (!h) return 3'd4;
    return 3'd0;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one command and watch it to completion. inject_at>0 pulses a DMI write
  // (and cmderr_clr_i=inject_clr) in that busy cycle.
  task automatic run_cmd(input logic [31:0] c, input logic h, input logic wr_d0,
                         input logic [31:0] d0, input logic [31:0] base,
                         input int inject_at, input logic inject_cmd,
                         input logic [2:0] inject_clr, input string name);
    logic [2:0]  err;
    logic        acc;
    int          exp_busy, exp_en, busy_cnt, en_cnt;
    logic [31:0] exp_wdat;
    logic        finished;
    if (wr_d0) m_data0 = d0;
    exp_wdat = m_data0;
    if (m_cmderr != 3'd0) begin
      exp_busy = 0; exp_en = 0; acc = 1'b0;
    end else begin
      err = predict_err(c, h);
      acc = (err == 3'd0) && c[17];
      exp_busy = acc ? N + 2 : 2;
      exp_en   = acc ? N : 0;
      if (err != 3'd0) m_cmderr = err;
      if (inject_at > 0) begin
        if (m_cmderr == 3'd0) m_cmderr = 3'd1;
        else m_cmderr = m_cmderr & ~inject_clr;
      end
      if (acc && !c[16]) m_data0 = base + N;
    end

    hart_halted_i   = h;
    cmd_wr_en_i     = 1'b1;
    cmd_wr_data_i   = c;
    data0_wr_en_i   = wr_d0;
    data0_wr_data_i = d0;
    tick();
    cmd_wr_en_i   = 1'b0;
    data0_wr_en_i = 1'b0;
    resp_drive    = !c[16];
    resp_dat      = base;
    busy_cnt = 0; en_cnt = 0; finished = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk_i);
      if (!busy_o) begin
        finished = 1'b1;
        break;
      end
      busy_cnt++;
      if (dm_reg_rd_wr_en_o) begin
        en_cnt++;
        total++;
        if (dm_reg_rd_wr_address_o !== c[15:0] || dm_reg_rd_wr_o !== c[16]) begin
          bad++;
          $display("FAIL %s access addr/rd_wr: got %h/%b want %h/%b", name,
                   dm_reg_rd_wr_address_o, dm_reg_rd_wr_o, c[15:0], c[16]);
        end
        total++;
        if (c[16] && reg_bus !== exp_wdat) begin
          bad++;
          $display("FAIL %s write bus: got %h want %h", name, reg_bus, exp_wdat);
        end else if (!c[16] && reg_bus !== resp_dat) begin
          bad++;
          $display("FAIL %s read bus contended: got %h want %h", name, reg_bus, resp_dat);
        end
        // Responder presents a fresh word each access cycle; the DM keeps the last one.
        resp_dat = base + en_cnt;
      end
      if (cyc == inject_at) begin
        cmd_wr_en_i     = inject_cmd;
        cmd_wr_data_i   = 32'h002207B0;
        data0_wr_en_i   = !inject_cmd;
        data0_wr_data_i = ~exp_wdat;
        cmderr_clr_i    = inject_clr;
      end else begin
        cmd_wr_en_i   = 1'b0;
        data0_wr_en_i = 1'b0;
        cmderr_clr_i  = 3'd0;
      end
    end
    cmd_wr_en_i   = 1'b0;
    data0_wr_en_i = 1'b0;
    cmderr_clr_i  = 3'd0;
    resp_drive    = 1'b0;
    total++;
    if (!finished) begin
      bad++;
      $display("FAIL %s timeout: busy still %b after 40 cycles, want 0", name, busy_o);
    end
    total++;
    if (busy_cnt != exp_busy) begin
      bad++;
      $display("FAIL %s busy cycles: got %0d want %0d", name, busy_cnt, exp_busy);
    end
    total++;
    if (en_cnt != exp_en) begin
      bad++;
      $display("FAIL %s access cycles: got %0d want %0d", name, en_cnt, exp_en);
    end
    total++;
    if (cmderr_o !== m_cmderr) begin
      bad++;
      $display("FAIL %s cmderr: got %0d want %0d", name, cmderr_o, m_cmderr);
    end
    total++;
    if (data0_o !== m_data0) begin
      bad++;
      $display("FAIL %s data0: got %h want %h", name, data0_o, m_data0);
    end
    tick();
  endtask

  task automatic clear_err(input logic [2:0] mask, input string name);
    cmderr_clr_i = mask;
    tick();
    cmderr_clr_i = 3'd0;
    m_cmderr = m_cmderr & ~mask;
    @(negedge clk_i);
    total++;
    if (cmderr_o !== m_cmderr) begin
      bad++;
      $display("FAIL %s cmderr after clear: got %0d want %0d", name, cmderr_o, m_cmderr);
    end
    tick();
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    cmd_wr_en_i = 1'b0; cmd_wr_data_i = '0;
    data0_wr_en_i = 1'b0; data0_wr_data_i = '0;
    cmderr_clr_i = 3'd0; hart_halted_i = 1'b1;
    resp_drive = 1'b0; resp_dat = '0;
    m_data0 = '0; m_cmderr = 3'd0;
    tick(); tick();
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0 || cmderr_o !== 3'd0 || data0_o !== 32'h0) begin
      bad++;
      $display("FAIL reset status: busy=%b cmderr=%0d data0=%h want 0/0/0", busy_o, cmderr_o, data0_o);
    end
    total++;
    if (dm_reg_rd_wr_en_o !== 1'b0 || dm_reg_rd_wr_o !== 1'b0 || dm_reg_rd_wr_address_o !== 16'h0) begin
      bad++;
      $display("FAIL reset bus ctrl: en=%b rd_wr=%b addr=%h want 0/0/0",
               dm_reg_rd_wr_en_o, dm_reg_rd_wr_o, dm_reg_rd_wr_address_o);
    end
    tick();
    reset_i = 1'b1;
    tick();
  endtask

  task automatic test_write();
    run_cmd(32'h002307B0, 1'b1, 1'b1, 32'h00000013, 32'h0, 0, 1'b0, 3'd0, "write_dcsr");
  endtask

  task automatic test_read();
    run_cmd(32'h002207B1, 1'b1, 1'b0, 32'h0, 32'h80000040, 0, 1'b0, 3'd0, "read_dpc");
    run_cmd(32'h0022101F, 1'b1, 1'b0, 32'h0, 32'h1234ABCD, 0, 1'b0, 3'd0, "read_gpr31");
  endtask

  task automatic test_error_sticky();
    run_cmd(32'h00320000, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0, 3'd0, "bad_aarsize");
    run_cmd(32'h002307B0, 1'b1, 1'b1, 32'hCAFE0001, 32'h0, 0, 1'b0, 3'd0, "dropped_cmd");
    clear_err(3'b111, "clear_all");
    run_cmd(32'h00231000, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0, 3'd0, "after_clear");
  endtask

  task automatic test_not_halted();
    run_cmd(32'h002207B0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, 3'd0, "not_halted");
    clear_err(3'b100, "clear_halt_err");
  endtask

  task automatic test_busy_write();
    run_cmd(32'h002307B2, 1'b1, 1'b1, 32'h5555AAAA, 32'h0, 3, 1'b0, 3'd0, "busy_data0_wr");
    clear_err(3'b001, "clear_busy_err");
    run_cmd(32'h002207B0, 1'b1, 1'b0, 32'h0, 32'h00C0FFEE, 2, 1'b1, 3'd7, "busy_cmd_wr_with_clr");
    clear_err(3'b111, "clear_busy_err2");
  endtask

  task automatic test_reset_abort();
    m_data0 = 32'hDEADBEEF;
    hart_halted_i   = 1'b1;
    cmd_wr_en_i     = 1'b1;
    cmd_wr_data_i   = 32'h002307B0;
    data0_wr_en_i   = 1'b1;
    data0_wr_data_i = m_data0;
    tick();
    cmd_wr_en_i   = 1'b0;
    data0_wr_en_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    total++;
    if (dm_reg_rd_wr_en_o !== 1'b1) begin
      bad++;
      $display("FAIL abort precondition en: got %b want 1", dm_reg_rd_wr_en_o);
    end
    reset_i = 1'b0;
    tick();
    reset_i = 1'b1;
    m_data0 = '0; m_cmderr = 3'd0;
    resp_dat = 32'h5A5A1234;
    resp_drive = 1'b1;
    @(negedge clk_i);
    total++;
    if (dm_reg_rd_wr_en_o !== 1'b0 || busy_o !== 1'b0 || data0_o !== 32'h0 || cmderr_o !== 3'd0) begin
      bad++;
      $display("FAIL abort state: en=%b busy=%b data0=%h cmderr=%0d want 0/0/0/0",
               dm_reg_rd_wr_en_o, busy_o, data0_o, cmderr_o);
    end
    total++;
    if (reg_bus !== 32'h5A5A1234) begin
      bad++;
      $display("FAIL abort bus released: got %h want %h", reg_bus, 32'h5A5A1234);
    end
    resp_drive = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] c;
    logic [15:0] regno;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0: regno = 16'h07B0 + 16'($urandom_range(0, 2));
        1: regno = 16'h1000 + 16'($urandom_range(0, 31));
        2: regno = 16'h07B3;
        3: regno = 16'h0FFF;
        4: regno = 16'h1020;
        default: regno = 16'($urandom);
      endcase
      c = 32'h0;
      c[31:24] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'd0;
      c[23]    = 1'($urandom);
      c[22:20] = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd2;
      c[19]    = 1'($urandom);
      c[18]    = ($urandom_range(0, 7) == 0);
      c[17]    = ($urandom_range(0, 4) != 0);
      c[16]    = 1'($urandom);
      c[15:0]  = regno;
      run_cmd(c, $urandom_range(0, 5) != 0, 1'($urandom), $urandom, $urandom,
              0, 1'b0, 3'd0, "random");
      if (m_cmderr != 3'd0 && $urandom_range(0, 2) != 0)
        clear_err(3'($urandom), "random_clear");
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_error_sticky();
    test_not_halted();
    test_busy_write();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
